lmk01801_uwire_ctl: RTL and testbench
=====================================

Name: lmk01801_uwire_ctl

Overview:
- Sequencer that serializes 32-bit register words onto the LMK01801 MICROWIRE pins: CLKuWire, DATAuWire and LEuWire.
- Sits between the host/config bus or a boot-time init ROM walker and the LMK01801 pin wrapper.
- Replaces the passthrough of host-driven pins with a timed, self-contained write engine.
- One transaction per start pulse: 32 bits MSB first, then a latch-enable pulse, then an idle gap.

Parameters:
- HALF_DIV, 4: clk cycles per MICROWIRE half-period. Legal range 1..255; 8-bit counter.
- LE_HALVES, 1: number of half-periods that uwire_le is held high. Legal range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only while busy=0.
- wdata  in  32  word to send. Bits [31:4] are data, [3:0] are register address; MSB transmitted first.
- busy  out  1  high from the cycle after acceptance through the end of the gap.
- done  out  1  one-cycle pulse at completion.
- rdata  out  32  shifted-in readback word (see Optional Feature).
- uwire_clk  out  1  drives CLKuWire.
- uwire_data  out  1  drives DATAuWire.
- uwire_le  out  1  drives LEuWire.
- uwire_data_in  in  1  DATAuWire readback from the device.

Behaviour:
- Reset (asynchronous, rst_n=0): busy=0, done=0, rdata=0, uwire_clk=0, uwire_data=0, uwire_le=0. State=IDLE, half-period counter=0, bit counter=0.
- IDLE state:
  - start=1 latches wdata into the shift register.
  - Next cycle: busy=1, state=SHIFT_LO, bit counter=31, uwire_data=wdata[31].
- SHIFT_LO state:
  - uwire_clk=0 for HALF_DIV cycles; uwire_data is stable for the whole half-period.
  - Then go to SHIFT_HI.
- SHIFT_HI state:
  - uwire_clk=1 for HALF_DIV cycles. The device samples on the rising edge.
  - At the end of the half-period:
    - If bit counter > 0: decrement it, shift left, present the next bit, go to SHIFT_LO.
    - If bit counter = 0: go to LE_WAIT.
- LE_WAIT state:
  - uwire_clk=0, uwire_data=0 for HALF_DIV cycles (setup before LE).
- LATCH state:
  - uwire_le=1 for LE_HALVES*HALF_DIV cycles; uwire_clk=0, uwire_data=0.
- GAP state:
  - All three pins low for HALF_DIV cycles, then return to IDLE.
  - In the first IDLE cycle: busy=0 and done=1 for exactly one cycle.
- Total busy time = (64 + 2 + LE_HALVES) * HALF_DIV cycles. With defaults: 268 cycles.
- uwire_clk, uwire_data and uwire_le are registered outputs with no combinational path from inputs.
- start while busy=1 is ignored; no queueing. wdata changes while busy have no effect.
- start in the same cycle as done=1 is accepted, since busy=0 in that cycle. Back-to-back words are separated only by the GAP state.
- Reset asserted mid-transaction:
  - Pins drop low immediately; no LE pulse and no done.
  - The partial word is discarded; the device sees no latch.
- HALF_DIV=1: uwire_clk toggles every cycle (clk/2). Latencies scale accordingly.

Optional Feature:
- Macro: LMK01801_UWIRE_READBACK_EN.
- Defined:
  - uwire_data_in is sampled on the last clk cycle of each SHIFT_HI half-period and shifted into an internal register, MSB first.
  - When entering LE_WAIT, the 32 captured bits are copied to rdata.
  - rdata holds that value until the next transaction completes or reset.
- Undefined:
  - rdata is constant 0 and uwire_data_in is unused.
  - No capture logic is synthesized.

Test Plan:
- Single write, HALF_DIV=4, LE_HALVES=1, wdata=32'hA5A5_0013, start pulse at cycle 10:
  - busy rises at cycle 11.
  - A pin monitor reconstructs 32'hA5A5_0013 from the rising uwire_clk edges.
  - uwire_le is high for 4 cycles after the 32nd bit.
  - done pulses exactly once, at cycle 11+268.
- start re-pulsed at cycles 50 and 100 during a transaction -> ignored: exactly one done, one LE pulse, pin word unchanged.
- Back-to-back: start held high continuously with wdata=32'h0000_0001 then 32'h8000_0000 -> both words serialized correctly; second busy begins the cycle after the first done.
- rst_n pulled low at bit 15 -> all outputs 0 asynchronously (same cycle); no LE edge; no done. After release, a new start of 32'hFFFF_FFF0 completes normally.
- HALF_DIV=1 -> uwire_clk period is 2 clk cycles; total busy = 67 cycles; word integrity as in scenario 1.
- With LMK01801_UWIRE_READBACK_EN, uwire_data_in driven by a model returning 32'h1234_5678 -> rdata=32'h1234_5678 from LE_WAIT onward. Without the macro -> rdata stays 0.

Source files
------------

// File: rtl/lmk01801_uwire_ctl.sv
// LMK01801 MICROWIRE write sequencer: 32 bits MSB first, LE pulse, idle gap.
// Optional readback capture is enabled with `define LMK01801_UWIRE_READBACK_EN.
module lmk01801_uwire_ctl #(
    parameter int unsigned HALF_DIV  = 4,
    parameter int unsigned LE_HALVES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        uwire_clk,
    output logic        uwire_data,
    output logic        uwire_le,
    input  logic        uwire_data_in
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_LE_WAIT  = 3'd3,
        ST_LATCH    = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    localparam logic [7:0] HALF_END = 8'(HALF_DIV - 1);
    localparam logic [4:0] LE_END   = 5'(LE_HALVES - 1);

    state_t      r_state;
    logic [7:0]  r_hcnt;
    logic [4:0]  r_bit_cnt;
    logic [31:0] r_shreg;
    logic        r_busy;
    logic        r_done;
    logic        r_uwire_clk;
    logic        r_uwire_data;
    logic        r_uwire_le;

    state_t      w_state_nxt;
    logic [7:0]  w_hcnt_nxt;
    logic [4:0]  w_bit_nxt;
    logic [31:0] w_shreg_nxt;
    logic        w_busy_nxt;
    logic        w_done_nxt;
    logic        w_clk_nxt;
    logic        w_data_nxt;
    logic        w_le_nxt;
    logic        w_half_end;

    assign w_half_end = (r_hcnt == HALF_END);

    // Next-state and next-pin computation; pins are registered below so no input reaches them combinationally.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = 8'd0;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_clk_nxt   = r_uwire_clk;
        w_data_nxt  = r_uwire_data;
        w_le_nxt    = r_uwire_le;

        if ((r_state == ST_IDLE) || w_half_end) begin
            w_hcnt_nxt = 8'd0;
        end else begin
            w_hcnt_nxt = r_hcnt + 8'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT_LO;
                    w_busy_nxt  = 1'b1;
                    w_shreg_nxt = wdata;
                    w_bit_nxt   = 5'd31;
                    w_clk_nxt   = 1'b0;
                    w_data_nxt  = wdata[31];
                    w_le_nxt    = 1'b0;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_clk_nxt   = 1'b0;
                    w_data_nxt  = 1'b0;
                    w_le_nxt    = 1'b0;
                end
            end
            ST_SHIFT_LO: begin
                if (w_half_end) begin
                    w_state_nxt = ST_SHIFT_HI;
                    w_clk_nxt   = 1'b1;
                end else begin
                    w_state_nxt = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_HI: begin
                if (w_half_end && (r_bit_cnt != 5'd0)) begin
                    w_state_nxt = ST_SHIFT_LO;
                    w_bit_nxt   = r_bit_cnt - 5'd1;
                    w_shreg_nxt = {r_shreg[30:0], 1'b0};
                    w_clk_nxt   = 1'b0;
                    w_data_nxt  = r_shreg[30];
                end else if (w_half_end) begin
                    w_state_nxt = ST_LE_WAIT;
                    w_clk_nxt   = 1'b0;
                    w_data_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_SHIFT_HI;
                end
            end
            ST_LE_WAIT: begin
                if (w_half_end) begin
                    w_state_nxt = ST_LATCH;
                    w_le_nxt    = 1'b1;
                    w_bit_nxt   = 5'd0;
                end else begin
                    w_state_nxt = ST_LE_WAIT;
                end
            end
            ST_LATCH: begin
                // The bit counter is reused here to count LE half-periods.
                if (w_half_end && (r_bit_cnt == LE_END)) begin
                    w_state_nxt = ST_GAP;
                    w_le_nxt    = 1'b0;
                    w_bit_nxt   = 5'd0;
                end else if (w_half_end) begin
                    w_bit_nxt   = r_bit_cnt + 5'd1;
                end else begin
                    w_state_nxt = ST_LATCH;
                end
            end
            ST_GAP: begin
                if (w_half_end) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_GAP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_bit_nxt   = 5'd0;
                w_clk_nxt   = 1'b0;
                w_data_nxt  = 1'b0;
                w_le_nxt    = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_hcnt       <= 8'd0;
            r_bit_cnt    <= 5'd0;
            r_shreg      <= 32'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_uwire_clk  <= 1'b0;
            r_uwire_data <= 1'b0;
            r_uwire_le   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hcnt       <= w_hcnt_nxt;
            r_bit_cnt    <= w_bit_nxt;
            r_shreg      <= w_shreg_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_uwire_clk  <= w_clk_nxt;
            r_uwire_data <= w_data_nxt;
            r_uwire_le   <= w_le_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign uwire_clk  = r_uwire_clk;
    assign uwire_data = r_uwire_data;
    assign uwire_le   = r_uwire_le;

`ifdef LMK01801_UWIRE_READBACK_EN
    logic [31:0] r_cap;
    logic [31:0] r_rdata;

    // Sample readback on the last cycle of each high half; publish the word when moving to LE_WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap   <= 32'd0;
            r_rdata <= 32'd0;
        end else if ((r_state == ST_SHIFT_HI) && w_half_end) begin
            r_cap <= {r_cap[30:0], uwire_data_in};
            if (r_bit_cnt == 5'd0) begin
                r_rdata <= {r_cap[30:0], uwire_data_in};
            end else begin
                r_rdata <= r_rdata;
            end
        end else begin
            r_cap   <= r_cap;
            r_rdata <= r_rdata;
        end
    end

    assign rdata = r_rdata;
`else
    logic w_unused_din;
    assign w_unused_din = uwire_data_in;
    assign rdata        = 32'd0;
`endif

endmodule

// File: tb/tb_lmk01801_uwire_ctl.sv
// Scoreboard bench for lmk01801_uwire_ctl: HALF_DIV=4 and HALF_DIV=1 instances, pin-level word rebuild.
module tb_lmk01801_uwire_ctl;

    localparam int HD0 = 4;
    localparam int HD1 = 1;
    localparam int LEH = 1;
`ifdef LMK01801_UWIRE_READBACK_EN
    localparam logic [31:0] EXP_RD = 32'h1234_5678;
`else
    localparam logic [31:0] EXP_RD = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a [2];
    logic [31:0] wdata_a [2];
    logic        busy_a  [2];
    logic        done_a  [2];
    logic [31:0] rdata_a [2];
    logic        uclk_a  [2];
    logic        udata_a [2];
    logic        ule_a   [2];
    logic        din0;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clk = ~clk;

    lmk01801_uwire_ctl #(.HALF_DIV(HD0), .LE_HALVES(LEH)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_a[0]), .wdata(wdata_a[0]),
        .busy(busy_a[0]), .done(done_a[0]), .rdata(rdata_a[0]),
        .uwire_clk(uclk_a[0]), .uwire_data(udata_a[0]), .uwire_le(ule_a[0]),
        .uwire_data_in(din0)
    );

    lmk01801_uwire_ctl #(.HALF_DIV(HD1), .LE_HALVES(LEH)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_a[1]), .wdata(wdata_a[1]),
        .busy(busy_a[1]), .done(done_a[1]), .rdata(rdata_a[1]),
        .uwire_clk(uclk_a[1]), .uwire_data(udata_a[1]), .uwire_le(ule_a[1]),
        .uwire_data_in(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    function automatic int exp_busy(input int d);
        return (64 + 2 + LEH) * ((d == 0) ? HD0 : HD1);
    endfunction

    function automatic int le_len(input int d);
        return LEH * ((d == 0) ? HD0 : HD1);
    endfunction

    // Device model: returns rb_word MSB first, advancing one bit after each falling uwire_clk.
    logic [31:0] rb_word = 32'h1234_5678;
    int          rb_idx  = 0;
    logic        rb_pclk = 1'b0;
    always @(posedge clk) begin
        if (!busy_a[0]) rb_idx <= 0;
        else if (rb_pclk && !uclk_a[0] && (rb_idx < 31)) rb_idx <= rb_idx + 1;
        rb_pclk <= uclk_a[0];
    end
    assign din0 = rb_word[5'(31 - rb_idx)];

    // Pin monitor / scoreboard checker.
    logic [31:0] acc      [2];
    int          bits     [2];
    int          busy_cnt [2];
    int          le_cnt   [2];
    logic        pclk     [2];
    logic        ple      [2];
    logic        pdone    [2];
    logic        le_seen  [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                acc[d] <= 32'd0; bits[d] <= 0; busy_cnt[d] <= 0; le_cnt[d] <= 0;
                pclk[d] <= 1'b0; ple[d] <= 1'b0; pdone[d] <= 1'b0; le_seen[d] <= 1'b0;
            end else begin
                if (uclk_a[d] && !pclk[d]) begin
                    acc[d]  <= {acc[d][30:0], udata_a[d]};
                    bits[d] <= bits[d] + 1;
                end
                if (ule_a[d] && !ple[d]) begin
                    if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                        fail_now($sformatf("unexpected_le_dut%0d", d));
                    end else begin
                        check($sformatf("word_dut%0d", d), acc[d], (d == 0) ? q0.pop_front() : q1.pop_front());
                        check($sformatf("bitcount_dut%0d", d), 32'(bits[d]), 32'd32);
                        if (d == 0) check("rdata_at_le", rdata_a[0], EXP_RD);
                    end
                    acc[d]     <= 32'd0;
                    bits[d]    <= 0;
                    le_seen[d] <= 1'b1;
                end
                if (ule_a[d]) begin
                    le_cnt[d] <= le_cnt[d] + 1;
                end else if (ple[d]) begin
                    check($sformatf("le_width_dut%0d", d), 32'(le_cnt[d]), 32'(le_len(d)));
                    le_cnt[d] <= 0;
                end
                if (done_a[d]) begin
                    check($sformatf("done_after_le_dut%0d", d), {31'd0, le_seen[d]}, 32'd1);
                    check($sformatf("busy_len_dut%0d", d), 32'(busy_cnt[d]), 32'(exp_busy(d)));
                    if (d == 0) check("rdata_at_done", rdata_a[0], EXP_RD);
                    if (pdone[d]) fail_now($sformatf("done_two_cycles_dut%0d", d));
                    busy_cnt[d] <= 0;
                    le_seen[d]  <= 1'b0;
                end else if (busy_a[d]) begin
                    busy_cnt[d] <= busy_cnt[d] + 1;
                end
                pclk[d]  <= uclk_a[d];
                ple[d]   <= ule_a[d];
                pdone[d] <= done_a[d];
            end
        end
    end

    task automatic send(input int d, input logic [31:0] w, input bit expect_it);
        @(negedge clk);
        wdata_a[d] = w;
        start_a[d] = 1'b1;
        if (expect_it) begin
            if (d == 0) q0.push_back(w);
            else q1.push_back(w);
        end
        @(negedge clk);
        start_a[d] = 1'b0;
        check($sformatf("busy_rise_dut%0d", d), {31'd0, busy_a[d]}, 32'd1);
    endtask

    task automatic wait_done(input int d, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done_a[d]) break;
            @(negedge clk);
        end
        if (i == budget) fail_now($sformatf("timeout_done_dut%0d", d));
    endtask

    task automatic check_idle_pins(input int d, input string tag);
        check({tag, "_busy"}, {31'd0, busy_a[d]}, 32'd0);
        check({tag, "_done"}, {31'd0, done_a[d]}, 32'd0);
        check({tag, "_uclk"}, {31'd0, uclk_a[d]}, 32'd0);
        check({tag, "_udata"}, {31'd0, udata_a[d]}, 32'd0);
        check({tag, "_ule"}, {31'd0, ule_a[d]}, 32'd0);
        check({tag, "_rdata"}, rdata_a[d], 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_a[d] = 1'b0;
            wdata_a[d] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_idle_pins(0, "reset_dut4");
        check_idle_pins(1, "reset_dut1");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Single write.
        send(0, 32'hA5A5_0013, 1'b1);
        wait_done(0, 400);

        // Start pulses while busy are ignored.
        send(0, 32'h3C3C_5A5A, 1'b1);
        repeat (40) @(negedge clk);
        wdata_a[0] = 32'hDEAD_BEEF; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        repeat (50) @(negedge clk);
        wdata_a[0] = 32'h0000_0000; start_a[0] = 1'b1;
        @(negedge clk);
        start_a[0] = 1'b0;
        wait_done(0, 400);
        repeat (5) @(negedge clk);
        check("ignored_start_idle", {31'd0, busy_a[0]}, 32'd0);

        // Back-to-back with start held high.
        @(negedge clk);
        wdata_a[0] = 32'h0000_0001; start_a[0] = 1'b1;
        q0.push_back(32'h0000_0001);
        q0.push_back(32'h8000_0000);
        @(negedge clk);
        wdata_a[0] = 32'h8000_0000;
        wait_done(0, 400);
        @(negedge clk);
        check("b2b_busy_after_done", {31'd0, busy_a[0]}, 32'd1);
        start_a[0] = 1'b0;
        wait_done(0, 400);

        // Reset in the middle of a word.
        send(0, 32'h1357_9BDF, 1'b0);
        for (int i = 0; i < 400; i++) begin
            if (bits[0] >= 16) break;
            @(negedge clk);
        end
        check("abort_reached_bit15", {31'd0, (bits[0] >= 16)}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_pins(0, "abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(0, 32'hFFFF_FFF0, 1'b1);
        wait_done(0, 400);

        // HALF_DIV=1 instance.
        send(1, 32'hA5A5_0013, 1'b1);
        wait_done(1, 200);
        send(1, 32'h8000_0001, 1'b1);
        wait_done(1, 200);

        repeat (10) @(negedge clk);
        check("queue_empty_dut4", 32'(q0.size()), 32'd0);
        check("queue_empty_dut1", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
